// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter that funnels one cache-bus packet at a time from N private
// caches onto a single memory port and routes the completion back to the requester.
module cache_mem_arbiter #(
  parameter  int num_caches_p     = 2,
  parameter  int dma_data_width_p = 16,
  localparam int data_width_lp    = 32 * dma_data_width_p,
  localparam int pkt_width_lp     = 33 + data_width_lp
) (
  input  logic                                   clk_i,
  input  logic                                   nreset_i,
  input  logic [num_caches_p-1:0]                cb_valid_i,
  input  logic [num_caches_p*pkt_width_lp-1:0]   cb_pkt_i,
  output logic [num_caches_p-1:0]                cb_yumi_o,
  output logic [num_caches_p-1:0]                cb_valid_o,
  output logic [data_width_lp-1:0]               cb_data_o,
  output logic                                   mem_valid_o,
  input  logic                                   mem_ready_i,
  output logic                                   mem_we_o,
  output logic [31:0]                            mem_addr_o,
  output logic [data_width_lp-1:0]               mem_wdata_o,
  input  logic                                   mem_valid_i,
  input  logic [data_width_lp-1:0]               mem_data_i
);

  localparam int          idx_width_lp    = (num_caches_p > 1) ? $clog2(num_caches_p) : 1;
  localparam int          offset_width_lp = $clog2(4 * dma_data_width_p);
  localparam logic [31:0] addr_mask_lp    = ~((32'd1 << offset_width_lp) - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e                    state_r;
  state_e                    state_next_s;
  logic [idx_width_lp-1:0]   last_r;
  logic [idx_width_lp-1:0]   grant_r;
  logic [idx_width_lp-1:0]   grant_idx_s;
  logic [idx_width_lp-1:0]   scan_idx_s;
  logic                      grant_valid_s;
  logic [pkt_width_lp-1:0]   pkt_sel_s;
  logic                      we_r;
  logic [31:0]               addr_r;
  logic [data_width_lp-1:0]  wdata_r;
  logic [data_width_lp-1:0]  rdata_r;
  logic                      accept_s;
  logic                      mem_fire_s;
  logic                      capture_s;

  // Round-robin scan starting one past the last granted port, wrapping.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    scan_idx_s    = '0;
    for (int i = 1; i <= num_caches_p; i++) begin
      scan_idx_s = idx_width_lp'((int'(last_r) + i) % num_caches_p);
      if (!grant_valid_s && cb_valid_i[scan_idx_s]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = scan_idx_s;
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Select only the granted port's packet; other slices never reach the registers.
  always_comb begin
    pkt_sel_s = '0;
    for (int i = 0; i < num_caches_p; i++) begin
      if (grant_idx_s == idx_width_lp'(i)) begin
        pkt_sel_s = cb_pkt_i[i*pkt_width_lp +: pkt_width_lp];
      end else begin
        pkt_sel_s = pkt_sel_s;
      end
    end
  end

  assign accept_s   = (state_r == ST_IDLE) && grant_valid_s;
  assign mem_fire_s = (state_r == ST_REQ) && mem_ready_i;
  // A completion arriving on the request handshake cycle is taken as well.
  assign capture_s  = (mem_fire_s || (state_r == ST_WAIT)) && mem_valid_i;

  // State register.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ready_i && mem_valid_i) begin
          state_next_s = ST_RESP;
        end else if (mem_ready_i) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_valid_i) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; yumi is held low while reset is asserted.
  always_comb begin
    cb_yumi_o   = '0;
    cb_valid_o  = '0;
    mem_valid_o = (state_r == ST_REQ);
    for (int i = 0; i < num_caches_p; i++) begin
      cb_yumi_o[i]  = nreset_i && accept_s && (grant_idx_s == idx_width_lp'(i));
      cb_valid_o[i] = (state_r == ST_RESP) && (grant_r == idx_width_lp'(i));
    end
  end

  // Request latch on grant and response capture on completion.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      last_r  <= idx_width_lp'(num_caches_p - 1);
      grant_r <= '0;
      we_r    <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= '0;
      rdata_r <= '0;
    end else begin
      if (accept_s) begin
        last_r  <= grant_idx_s;
        grant_r <= grant_idx_s;
        we_r    <= pkt_sel_s[pkt_width_lp-1];
        addr_r  <= pkt_sel_s[pkt_width_lp-2 -: 32] & addr_mask_lp;
        wdata_r <= pkt_sel_s[data_width_lp-1:0];
      end else begin
        last_r  <= last_r;
      end
      if (capture_s) begin
        rdata_r <= mem_data_i;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign mem_we_o    = we_r;
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;
  assign cb_data_o   = rdata_r;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a table of per-cycle vectors followed by
// hand-written sequences for round-robin, backpressure, same-cycle completion and reset.
module tb_cache_mem_arbiter;

  localparam int N     = 2;
  localparam int DW    = 16;
  localparam int W     = 32 * DW;
  localparam int PKT_W = 33 + W;
  localparam int NV    = 16;

  logic             clk = 1'b0;
  logic             nreset;
  logic [N-1:0]     cb_valid;
  logic [N*PKT_W-1:0] cb_pkt;
  logic [N-1:0]     cb_yumi;
  logic [N-1:0]     cb_valid_out;
  logic [W-1:0]     cb_data;
  logic             mem_valid;
  logic             mem_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [W-1:0]     mem_wdata;
  logic             mem_valid_in;
  logic [W-1:0]     mem_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.num_caches_p(N), .dma_data_width_p(DW)) dut (
    .clk_i      (clk),
    .nreset_i   (nreset),
    .cb_valid_i (cb_valid),
    .cb_pkt_i   (cb_pkt),
    .cb_yumi_o  (cb_yumi),
    .cb_valid_o (cb_valid_out),
    .cb_data_o  (cb_data),
    .mem_valid_o(mem_valid),
    .mem_ready_i(mem_ready),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_valid_i(mem_valid_in),
    .mem_data_i (mem_data)
  );

  typedef struct {
    logic [1:0]  cbv;
    logic        rdy;
    logic        mvi;
    logic [31:0] dw;
    logic [1:0]  e_yumi;
    logic [1:0]  e_cbv;
    logic        e_mvo;
    logic        e_we;
    logic [31:0] e_addr;
    logic        e_chk_d;
    logic [31:0] e_dw;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [W-1:0] pattern(input logic [31:0] base);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < DW; k++) v[k*32 +: 32] = base + 32'(k);
    return v;
  endfunction

  function automatic logic [W-1:0] rep(input logic [31:0] dw);
    return {DW{dw}};
  endfunction

  function automatic logic [PKT_W-1:0] mk_pkt(input logic we, input logic [31:0] addr,
                                              input logic [31:0] base);
    return {we, addr, pattern(base)};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    nreset       = 1'b0;
    cb_valid     = 2'b00;
    mem_ready    = 1'b0;
    mem_valid_in = 1'b0;
    mem_data     = '0;
    next_cycle();
    nreset       = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         gq[$];
    logic       hs;
    int         got;

    // Reset state, with both caches requesting to prove yumi stays low.
    nreset       = 1'b0;
    cb_valid     = 2'b11;
    mem_ready    = 1'b0;
    mem_valid_in = 1'b0;
    mem_data     = '0;
    cb_pkt       = {mk_pkt(1'b1, 32'h0000_0100, 32'h1234_0000), mk_pkt(1'b0, 32'h0000_0047, 32'h0)};
    #3;
    chk("rst_yumi",     W'(cb_yumi), W'(2'b00));
    chk("rst_cb_valid", W'(cb_valid_out), W'(2'b00));
    chk("rst_mem_valid", W'(mem_valid), W'(1'b0));
    chk("rst_mem_we",   W'(mem_we), W'(1'b0));
    chk("rst_mem_addr", W'(mem_addr), W'(32'h0));
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_cb_data",  cb_data, '0);
    next_cycle();
    cb_valid = 2'b00;
    nreset   = 1'b1;

    // Read L=3, stray completion in IDLE, write ack, then contention after cache1.
    vecs[0]  = '{2'b01, 1'b0, 1'b0, 32'h0,         2'b01, 2'b00, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[1]  = '{2'b00, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, 1'b1, 1'b0, 32'h40,  1'b0, 32'h0};
    vecs[2]  = '{2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[3]  = '{2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[4]  = '{2'b00, 1'b0, 1'b1, 32'hA5A5_A5A5, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[5]  = '{2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b01, 1'b0, 1'b0, 32'h0,   1'b1, 32'hA5A5_A5A5};
    vecs[6]  = '{2'b00, 1'b0, 1'b1, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   1'b1, 32'hA5A5_A5A5};
    vecs[7]  = '{2'b10, 1'b0, 1'b0, 32'h0,         2'b10, 2'b00, 1'b0, 1'b0, 32'h0,   1'b1, 32'hA5A5_A5A5};
    vecs[8]  = '{2'b00, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    vecs[9]  = '{2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[10] = '{2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b10, 1'b0, 1'b0, 32'h0,   1'b1, 32'hDEAD_BEEF};
    vecs[11] = '{2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[12] = '{2'b11, 1'b0, 1'b0, 32'h0,         2'b01, 2'b00, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[13] = '{2'b00, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, 1'b1, 1'b0, 32'h40,  1'b0, 32'h0};
    vecs[14] = '{2'b00, 1'b0, 1'b1, 32'h1111_1111, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[15] = '{2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b01, 1'b0, 1'b0, 32'h0,   1'b1, 32'h1111_1111};

    for (int i = 0; i < NV; i++) begin
      cb_valid     = vecs[i].cbv;
      mem_ready    = vecs[i].rdy;
      mem_valid_in = vecs[i].mvi;
      mem_data     = rep(vecs[i].dw);
      @(negedge clk);
      chk($sformatf("v%0d_yumi", i),      W'(cb_yumi), W'(vecs[i].e_yumi));
      chk($sformatf("v%0d_cb_valid", i),  W'(cb_valid_out), W'(vecs[i].e_cbv));
      chk($sformatf("v%0d_mem_valid", i), W'(mem_valid), W'(vecs[i].e_mvo));
      if (vecs[i].e_mvo) begin
        chk($sformatf("v%0d_mem_we", i),   W'(mem_we), W'(vecs[i].e_we));
        chk($sformatf("v%0d_mem_addr", i), W'(mem_addr), W'(vecs[i].e_addr));
        if (vecs[i].e_we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, pattern(32'h1234_0000));
      end
      if (vecs[i].e_chk_d) chk($sformatf("v%0d_cb_data", i), cb_data, rep(vecs[i].e_dw));
      next_cycle();
    end

    // Round-robin from reset with both caches requesting, memory latency 1.
    do_reset();
    cb_valid  = 2'b11;
    mem_ready = 1'b1;
    hs        = 1'b0;
    for (int c = 0; c < 60 && gq.size() < 4; c++) begin
      mem_valid_in = hs;
      mem_data     = rep(32'(c));
      @(negedge clk);
      chk("rr_yumi_not_both", W'(cb_yumi == 2'b11), W'(1'b0));
      if (cb_yumi == 2'b01) gq.push_back(0);
      else if (cb_yumi == 2'b10) gq.push_back(1);
      hs = mem_valid && mem_ready;
      next_cycle();
    end
    chk("rr_grant_count", W'(gq.size()), W'(4));
    for (int k = 0; k < 4; k++) begin
      got = (k < gq.size()) ? gq[k] : -1;
      chk($sformatf("rr_grant%0d", k), W'(got), W'(k % 2));
    end

    // Backpressure: request held stable and no second grant while blocked.
    do_reset();
    cb_pkt[PKT_W-1:0] = mk_pkt(1'b1, 32'h0000_02C5, 32'hB000_0000);
    cb_valid = 2'b01;
    @(negedge clk);
    chk("bp_yumi_grant", W'(cb_yumi), W'(2'b01));
    next_cycle();
    cb_valid = 2'b11;
    cb_pkt[PKT_W-1:0] = mk_pkt(1'b0, 32'h0000_0FFC, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_mem_valid", k), W'(mem_valid), W'(1'b1));
      chk($sformatf("bp%0d_mem_we", k),    W'(mem_we), W'(1'b1));
      chk($sformatf("bp%0d_mem_addr", k),  W'(mem_addr), W'(32'h0000_02C0));
      chk($sformatf("bp%0d_mem_wdata", k), mem_wdata, pattern(32'hB000_0000));
      chk($sformatf("bp%0d_yumi", k),      W'(cb_yumi), W'(2'b00));
      next_cycle();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_mem_valid", W'(mem_valid), W'(1'b1));
    next_cycle();
    mem_ready    = 1'b0;
    mem_valid_in = 1'b1;
    mem_data     = rep(32'h7777_7777);
    @(negedge clk);
    chk("bp_wait_cb_valid", W'(cb_valid_out), W'(2'b00));
    chk("bp_wait_yumi",     W'(cb_yumi), W'(2'b00));
    next_cycle();
    mem_valid_in = 1'b0;
    @(negedge clk);
    chk("bp_resp_cb_valid", W'(cb_valid_out), W'(2'b01));
    chk("bp_resp_cb_data",  cb_data, rep(32'h7777_7777));
    chk("bp_resp_yumi",     W'(cb_yumi), W'(2'b00));
    next_cycle();
    @(negedge clk);
    chk("bp_next_grant", W'(cb_yumi), W'(2'b10));
    cb_pkt[PKT_W-1:0] = mk_pkt(1'b0, 32'h0000_0047, 32'h0);

    // Completion in the same cycle as the request handshake skips WAIT.
    do_reset();
    cb_valid = 2'b10;
    @(negedge clk);
    chk("sc_yumi", W'(cb_yumi), W'(2'b10));
    next_cycle();
    cb_valid     = 2'b00;
    mem_ready    = 1'b1;
    mem_valid_in = 1'b1;
    mem_data     = rep(32'h5A5A_0001);
    @(negedge clk);
    chk("sc_mem_valid", W'(mem_valid), W'(1'b1));
    chk("sc_mem_we",    W'(mem_we), W'(1'b1));
    chk("sc_mem_addr",  W'(mem_addr), W'(32'h0000_0100));
    next_cycle();
    mem_ready    = 1'b0;
    mem_valid_in = 1'b0;
    mem_data     = '0;
    @(negedge clk);
    chk("sc_resp_cb_valid", W'(cb_valid_out), W'(2'b10));
    chk("sc_resp_cb_data",  cb_data, rep(32'h5A5A_0001));
    next_cycle();
    @(negedge clk);
    chk("sc_pulse_once", W'(cb_valid_out), W'(2'b00));

    // Asynchronous reset while waiting for memory.
    do_reset();
    cb_pkt[PKT_W-1:0] = mk_pkt(1'b1, 32'h0000_0047, 32'hC000_0000);
    cb_valid = 2'b01;
    @(negedge clk);
    chk("ar_yumi", W'(cb_yumi), W'(2'b01));
    next_cycle();
    cb_valid  = 2'b00;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("ar_req_mem_valid", W'(mem_valid), W'(1'b1));
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("ar_wait_mem_we", W'(mem_we), W'(1'b1));
    #2;
    nreset = 1'b0;
    #1;
    chk("ar_mem_valid", W'(mem_valid), W'(1'b0));
    chk("ar_mem_we",    W'(mem_we), W'(1'b0));
    chk("ar_mem_addr",  W'(mem_addr), W'(32'h0));
    chk("ar_mem_wdata", mem_wdata, '0);
    chk("ar_cb_valid",  W'(cb_valid_out), W'(2'b00));
    chk("ar_cb_data",   cb_data, '0);
    next_cycle();
    nreset       = 1'b1;
    mem_valid_in = 1'b1;
    mem_data     = rep(32'h9999_9999);
    @(negedge clk);
    chk("ar_late_cb_valid0", W'(cb_valid_out), W'(2'b00));
    next_cycle();
    mem_valid_in = 1'b0;
    @(negedge clk);
    chk("ar_late_cb_valid1", W'(cb_valid_out), W'(2'b00));
    chk("ar_late_cb_data",   cb_data, '0);
    next_cycle();
    cb_valid = 2'b11;
    @(negedge clk);
    chk("ar_next_grant", W'(cb_yumi), W'(2'b01));
    next_cycle();
    cb_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
